// File: rtl/sensor_seq_pkg.sv
// Shared types and default timing for the sensor frame sequencer.
// The frame phase encoding lives here so the top and the bench agree on it.
package sensor_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ERASE    = 3'd1,
    CONV_REF = 3'd2,
    EXPOSE   = 3'd3,
    CONVERT  = 3'd4,
    READ     = 3'd5
  } seq_state_t;

  localparam int DEF_PIXEL_COUNT    = 4;
  localparam int DEF_CNT_W          = 16;
  localparam int DEF_ERASE_CYCLES   = 5;
  localparam int DEF_CONVERT_CYCLES = 255;

  // A single-pixel array would give $clog2 of 0, so keep at least one bit.
  function automatic int idx_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/sensor_sequencer.sv
// Frame sequencer: erase, optional CDS reference conversion, exposure, signal conversion, readout.
// Optional 32-bit frame_count output enabled by defining SENSOR_SEQ_FRAME_COUNT_EN.
//
// state    | meaning
// IDLE     | waiting for enable (abort blocks start)
// ERASE    | pixel reset for ERASE_CYCLES
// CONV_REF | CDS reference conversion, corr high, CONVERT_CYCLES
// EXPOSE   | integration for the latched exposure length
// CONVERT  | signal conversion, CONVERT_CYCLES
// READ     | pixel readout, index advances on rd_ready
module sensor_sequencer
  import sensor_seq_pkg::*;
#(
  parameter int PIXEL_COUNT    = DEF_PIXEL_COUNT,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int ERASE_CYCLES   = DEF_ERASE_CYCLES,
  parameter int CONVERT_CYCLES = DEF_CONVERT_CYCLES
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic                                cont_mode,
  input  logic                                cds,
  input  logic [CNT_W-1:0]                    expose_cycles,
  input  logic                                abort,
  input  logic                                rd_ready,
  output logic                                erase,
  output logic                                expose,
  output logic                                convert,
  output logic                                read,
  output logic                                idle,
  output logic                                corr,
  output logic [idx_width(PIXEL_COUNT)-1:0]   pixel_select,
  output logic                                pixel_valid,
  output logic                                frame_done
`ifdef SENSOR_SEQ_FRAME_COUNT_EN
  ,
  output logic [31:0]                         frame_count
`endif
);

  localparam int IDX_W = idx_width(PIXEL_COUNT);

  seq_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_cds;
  logic [CNT_W-1:0] r_expose;

  seq_state_t       w_next;
  logic             w_start;
  logic             w_frame_done;
  logic             w_last_pix;

  assign w_last_pix = (r_idx == IDX_W'(PIXEL_COUNT - 1));

  always_comb begin
    w_next       = r_state;
    w_start      = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && !abort) begin
          w_next  = ERASE;
          w_start = 1'b1;
        end
      end
      ERASE: begin
        if (r_cnt == CNT_W'(ERASE_CYCLES - 1))
          w_next = r_cds ? CONV_REF : EXPOSE;
      end
      CONV_REF: begin
        if (r_cnt == CNT_W'(CONVERT_CYCLES - 1))
          w_next = EXPOSE;
      end
      EXPOSE: begin
        if (r_cnt == r_expose - CNT_W'(1))
          w_next = CONVERT;
      end
      CONVERT: begin
        if (r_cnt == CNT_W'(CONVERT_CYCLES - 1))
          w_next = READ;
      end
      READ: begin
        if (rd_ready && w_last_pix) begin
          w_frame_done = 1'b1;
          if (cont_mode) begin
            w_next  = ERASE;
            w_start = 1'b1;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
    // Abort overrides everything, including the final-pixel acceptance.
    if (abort && (r_state != IDLE)) begin
      w_next       = IDLE;
      w_start      = 1'b0;
      w_frame_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_cds    <= 1'b0;
      r_expose <= '0;
    end else begin
      r_state <= w_next;
      // Saturating so an indefinite READ or IDLE can never wrap the counter.
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_cnt != '1)
        r_cnt <= r_cnt + CNT_W'(1);
      if (w_next != r_state)
        r_idx <= '0;
      else if ((r_state == READ) && rd_ready && !w_last_pix)
        r_idx <= r_idx + IDX_W'(1);
      if (w_start) begin
        r_cds    <= cds;
        r_expose <= (expose_cycles == '0) ? CNT_W'(1) : expose_cycles;
      end
    end
  end

  assign idle         = (r_state == IDLE);
  assign erase        = (r_state == ERASE);
  assign expose       = (r_state == EXPOSE);
  assign convert      = (r_state == CONV_REF) || (r_state == CONVERT);
  assign corr         = (r_state == CONV_REF);
  assign read         = (r_state == READ);
  assign pixel_valid  = read;
  assign pixel_select = read ? r_idx : '0;
  assign frame_done   = w_frame_done;

`ifdef SENSOR_SEQ_FRAME_COUNT_EN
  logic [31:0] r_frame_count;

  always_ff @(posedge clk) begin
    if (reset)
      r_frame_count <= '0;
    else if (w_frame_done)
      r_frame_count <= r_frame_count + 32'd1;
  end

  assign frame_count = r_frame_count;
`endif

endmodule

// File: tb/tb_sensor_sequencer.sv
// Directed self-checking bench for sensor_sequencer at default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sensor_sequencer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        cont_mode;
  logic        cds;
  logic [15:0] expose_cycles;
  logic        abort;
  logic        rd_ready;
  logic        erase, expose, convert, read, idle, corr;
  logic [1:0]  pixel_select;
  logic        pixel_valid;
  logic        frame_done;
`ifdef SENSOR_SEQ_FRAME_COUNT_EN
  logic [31:0] frame_count;
`endif

  int tests_run;
  int tests_failed;
  int fd_count;
  int len;

  int rdy_pat [7] = '{1, 0, 0, 1, 1, 0, 1};
  int sel_exp [7] = '{0, 1, 1, 1, 2, 3, 3};

  sensor_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .cont_mode     (cont_mode),
    .cds           (cds),
    .expose_cycles (expose_cycles),
    .abort         (abort),
    .rd_ready      (rd_ready),
    .erase         (erase),
    .expose        (expose),
    .convert       (convert),
    .read          (read),
    .idle          (idle),
    .corr          (corr),
    .pixel_select  (pixel_select),
    .pixel_valid   (pixel_valid),
    .frame_done    (frame_done)
`ifdef SENSOR_SEQ_FRAME_COUNT_EN
    ,
    .frame_count   (frame_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (frame_done) fd_count++;

  // 0 idle, 1 erase, 2 reference conversion, 3 expose, 4 signal conversion, 5 read, 9 illegal.
  function automatic int phase_of();
    if ($countones({erase, expose, convert, read, idle}) != 1) return 9;
    if (corr && !convert) return 9;
    if (pixel_valid !== read) return 9;
    if (idle) return 0;
    if (erase) return 1;
    if (convert && corr) return 2;
    if (expose) return 3;
    if (convert) return 4;
    return 5;
  endfunction

  task automatic phase_len(input int ph, output int n);
    n = 0;
    while (phase_of() == ph && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic start_frame();
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (idle !== 1'b1) begin
      tests_failed++; $display("FAIL reset_idle: got %b want 1", idle);
    end
    tests_run++;
    if ({erase, expose, convert, read, corr, pixel_valid, frame_done} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b want 0000000", {erase, expose, convert, read, corr, pixel_valid, frame_done});
    end
    tests_run++;
    if (pixel_select !== 2'd0) begin
      tests_failed++; $display("FAIL reset_pixel_select: got %0d want 0", pixel_select);
    end
`ifdef SENSOR_SEQ_FRAME_COUNT_EN
    tests_run++;
    if (frame_count !== 32'd0) begin
      tests_failed++; $display("FAIL reset_frame_count: got %0d want 0", frame_count);
    end
`endif
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (phase_of() !== 0) begin
      tests_failed++; $display("FAIL idle_after_reset: phase %0d want 0", phase_of());
    end
  endtask

  task automatic test_basic_frame();
    cds = 1'b0; expose_cycles = 16'd10; rd_ready = 1'b1; cont_mode = 1'b0;
    start_frame();
    phase_len(1, len);
    tests_run++;
    if (len != 5) begin tests_failed++; $display("FAIL basic_erase_len: got %0d want 5", len); end
    phase_len(3, len);
    tests_run++;
    if (len != 10) begin tests_failed++; $display("FAIL basic_expose_len: got %0d want 10", len); end
    phase_len(4, len);
    tests_run++;
    if (len != 255) begin tests_failed++; $display("FAIL basic_convert_len: got %0d want 255", len); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (phase_of() != 5 || pixel_select !== 2'(i) || frame_done !== (i == 3)) begin
        tests_failed++;
        $display("FAIL basic_read_%0d: phase %0d sel %0d done %b want 5 %0d %b", i, phase_of(), pixel_select, frame_done, i, i == 3);
      end
      @(negedge clk);
    end
    tests_run++;
    if (phase_of() != 0) begin tests_failed++; $display("FAIL basic_back_idle: phase %0d want 0", phase_of()); end
  endtask

  task automatic test_cds();
    cds = 1'b1; expose_cycles = 16'd3; rd_ready = 1'b1; cont_mode = 1'b0;
    start_frame();
    cds = 1'b0;
    phase_len(1, len);
    tests_run++;
    if (len != 5) begin tests_failed++; $display("FAIL cds_erase_len: got %0d want 5", len); end
    phase_len(2, len);
    tests_run++;
    if (len != 255) begin tests_failed++; $display("FAIL cds_ref_len: got %0d want 255", len); end
    phase_len(3, len);
    tests_run++;
    if (len != 3) begin tests_failed++; $display("FAIL cds_expose_len: got %0d want 3", len); end
    phase_len(4, len);
    tests_run++;
    if (len != 255) begin tests_failed++; $display("FAIL cds_signal_conv_len: got %0d want 255 with corr low", len); end
    phase_len(5, len);
    tests_run++;
    if (len != 4) begin tests_failed++; $display("FAIL cds_read_len: got %0d want 4", len); end
    tests_run++;
    if (phase_of() != 0) begin tests_failed++; $display("FAIL cds_back_idle: phase %0d want 0", phase_of()); end
  endtask

  task automatic test_ready_flow();
    cds = 1'b0; expose_cycles = 16'd1; rd_ready = 1'b0; cont_mode = 1'b0;
    start_frame();
    phase_len(1, len);
    phase_len(3, len);
    phase_len(4, len);
    repeat (20) @(negedge clk);
    tests_run++;
    if (phase_of() != 5 || pixel_select !== 2'd0) begin
      tests_failed++; $display("FAIL ready_hold: phase %0d sel %0d want 5 0", phase_of(), pixel_select);
    end
    for (int i = 0; i < 7; i++) begin
      rd_ready = rdy_pat[i][0];
      #1;
      tests_run++;
      if (pixel_select !== 2'(sel_exp[i]) || frame_done !== (i == 6)) begin
        tests_failed++;
        $display("FAIL ready_step_%0d: sel %0d done %b want %0d %b", i, pixel_select, frame_done, sel_exp[i], i == 6);
      end
      @(negedge clk);
    end
    rd_ready = 1'b0;
    tests_run++;
    if (phase_of() != 0) begin tests_failed++; $display("FAIL ready_back_idle: phase %0d want 0", phase_of()); end
  endtask

  task automatic test_cont_mode();
    int fd0;
    fd0 = fd_count;
    cds = 1'b0; expose_cycles = 16'd10; rd_ready = 1'b1; cont_mode = 1'b1;
    start_frame();
    phase_len(1, len);
    len = 0;
    while (phase_of() == 3 && len < 2000) begin
      len++;
      if (len == 3) expose_cycles = 16'd20;
      @(negedge clk);
    end
    tests_run++;
    if (len != 10) begin tests_failed++; $display("FAIL cont_expose1_len: got %0d want 10", len); end
    phase_len(4, len);
    phase_len(5, len);
    tests_run++;
    if (phase_of() != 1) begin tests_failed++; $display("FAIL cont_restart_erase: phase %0d want 1", phase_of()); end
    cont_mode = 1'b0;
    phase_len(1, len);
    tests_run++;
    if (len != 5) begin tests_failed++; $display("FAIL cont_erase2_len: got %0d want 5", len); end
    phase_len(3, len);
    tests_run++;
    if (len != 20) begin tests_failed++; $display("FAIL cont_expose2_len: got %0d want 20", len); end
    phase_len(4, len);
    phase_len(5, len);
    tests_run++;
    if (phase_of() != 0 || fd_count != fd0 + 2) begin
      tests_failed++; $display("FAIL cont_end: phase %0d frames %0d want 0 %0d", phase_of(), fd_count - fd0, 2);
    end
  endtask

  task automatic test_abort();
    int fd0;
`ifdef SENSOR_SEQ_FRAME_COUNT_EN
    logic [31:0] fc0;
    fc0 = frame_count;
`endif
    fd0 = fd_count;
    cds = 1'b0; expose_cycles = 16'd10; rd_ready = 1'b1; cont_mode = 1'b0;
    start_frame();
    phase_len(1, len);
    repeat (4) @(negedge clk);
    tests_run++;
    if (phase_of() != 3) begin tests_failed++; $display("FAIL abort_expose_pos: phase %0d want 3", phase_of()); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests_run++;
    if (phase_of() != 0) begin tests_failed++; $display("FAIL abort_expose_idle: phase %0d want 0", phase_of()); end
    @(negedge clk);
    tests_run++;
    if (phase_of() != 0) begin tests_failed++; $display("FAIL abort_stays_idle: phase %0d want 0", phase_of()); end

    start_frame();
    phase_len(1, len);
    phase_len(3, len);
    phase_len(4, len);
    repeat (3) @(negedge clk);
    tests_run++;
    if (pixel_select !== 2'd3) begin tests_failed++; $display("FAIL abort_last_pix_pos: sel %0d want 3", pixel_select); end
    abort = 1'b1;
    #1;
    tests_run++;
    if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL abort_last_pix_done: got %b want 0", frame_done); end
    @(negedge clk);
    abort = 1'b0;
    tests_run++;
    if (phase_of() != 0 || fd_count != fd0) begin
      tests_failed++; $display("FAIL abort_last_pix_idle: phase %0d frames %0d want 0 0", phase_of(), fd_count - fd0);
    end
`ifdef SENSOR_SEQ_FRAME_COUNT_EN
    tests_run++;
    if (frame_count !== fc0) begin tests_failed++; $display("FAIL abort_frame_count: got %0d want %0d", frame_count, fc0); end
`endif

    enable = 1'b1; abort = 1'b1;
    @(negedge clk);
    enable = 1'b0; abort = 1'b0;
    tests_run++;
    if (phase_of() != 0) begin tests_failed++; $display("FAIL abort_blocks_start: phase %0d want 0", phase_of()); end
  endtask

  task automatic test_zero_exposure_and_reset();
    cds = 1'b0; expose_cycles = 16'd0; rd_ready = 1'b1; cont_mode = 1'b0;
    start_frame();
    phase_len(1, len);
    phase_len(3, len);
    tests_run++;
    if (len != 1) begin tests_failed++; $display("FAIL zero_expose_len: got %0d want 1", len); end
    repeat (100) @(negedge clk);
    tests_run++;
    if (phase_of() != 4) begin tests_failed++; $display("FAIL mid_convert_pos: phase %0d want 4", phase_of()); end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (idle !== 1'b1 || {erase, expose, convert, read, corr, frame_done} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_convert: idle %b others %b want 1 000000", idle, {erase, expose, convert, read, corr, frame_done});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; fd_count = 0;
    reset = 1'b1; enable = 1'b0; cont_mode = 1'b0; cds = 1'b0;
    expose_cycles = 16'd0; abort = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_frame();
    test_cds();
    test_ready_flow();
    test_cont_mode();
    test_abort();
    test_zero_exposure_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
